mem_bus_arbiter: RTL

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Arbitrates instruction-cache fills and data-cache fills/write-backs onto one memory port.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on contention (default: data side always wins).
module mem_bus_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              I_READ,
    input  logic [ADDR_W-1:0] I_ADDR,
    output logic [DATA_W-1:0] I_READDATA,
    output logic              I_BUSYWAIT,
    input  logic              D_READ,
    input  logic              D_WRITE,
    input  logic [ADDR_W-1:0] D_ADDR,
    input  logic [DATA_W-1:0] D_WRITEDATA,
    output logic [DATA_W-1:0] D_READDATA,
    output logic              D_BUSYWAIT,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WRITEDATA,
    input  logic [DATA_W-1:0] MEM_READDATA,
    input  logic              MEM_BUSYWAIT
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        TURN    = 2'd3
    } state_t;

    state_t state;
    logic   started;
    logic   d_pend;
    logic   done;
    logic   grant_d;

    assign d_pend = D_READ | D_WRITE;
    // The first SERVE cycle never completes: memory has not yet seen the registered strobe.
    assign done   = ((state == SERVE_I) || (state == SERVE_D)) && started && !MEM_BUSYWAIT;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d;
    assign grant_d = d_pend && (!I_READ || !last_d);
`else
    assign grant_d = d_pend;
`endif

    assign I_BUSYWAIT = I_READ && !((state == SERVE_I) && done);
    assign D_BUSYWAIT = d_pend && !((state == SERVE_D) && done);
    assign I_READDATA = (state == SERVE_I) ? MEM_READDATA : '0;
    assign D_READDATA = (state == SERVE_D) ? MEM_READDATA : '0;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= IDLE;
            started       <= 1'b0;
            MEM_READ      <= 1'b0;
            MEM_WRITE     <= 1'b0;
            MEM_ADDR      <= '0;
            MEM_WRITEDATA <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    started <= 1'b0;
                    if (grant_d) begin
                        state         <= SERVE_D;
                        MEM_READ      <= D_READ;
                        MEM_WRITE     <= D_WRITE;
                        MEM_ADDR      <= D_ADDR;
                        MEM_WRITEDATA <= D_WRITEDATA;
`ifdef ARB_ROUND_ROBIN_EN
                        last_d        <= 1'b1;
`endif
                    end else if (I_READ) begin
                        state         <= SERVE_I;
                        MEM_READ      <= 1'b1;
                        MEM_WRITE     <= 1'b0;
                        MEM_ADDR      <= I_ADDR;
                        MEM_WRITEDATA <= '0;
`ifdef ARB_ROUND_ROBIN_EN
                        last_d        <= 1'b0;
`endif
                    end
                end
                SERVE_I, SERVE_D: begin
                    // A requester dropping its line mid-access does not abort memory.
                    started <= 1'b1;
                    if (done) begin
                        state     <= TURN;
                        started   <= 1'b0;
                        MEM_READ  <= 1'b0;
                        MEM_WRITE <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
